// File: rtl/ascon_pack.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ascon_pack : shared types and round-count constants for ASCON    |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package ascon_pack;

  typedef enum logic {CNT_IDLE, CNT_RUN} cnt_state_t;

  localparam int unsigned ROUND_MAX = 11;
  localparam int unsigned P12_START = 0;
  localparam int unsigned P6_START  = 6;

endpackage
`default_nettype wire

// File: rtl/compteur_rondes_param.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | compteur_rondes_param : round counter sequencing ASCON perms     |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module compteur_rondes_param
  import ascon_pack::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_VAL = ROUND_MAX,
  parameter int unsigned INIT_A  = P12_START,
  parameter int unsigned INIT_B  = P6_START
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             en_i,
  input  logic             init_a_i,
  input  logic             init_b_i,
  output logic [WIDTH-1:0] data_o,
  output logic             busy_o,
  output logic             last_o,
  output logic             done_o
);

  localparam logic [WIDTH-1:0] C_MAX    = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] C_INIT_A = WIDTH'(INIT_A);
  localparam logic [WIDTH-1:0] C_INIT_B = WIDTH'(INIT_B);
  localparam logic [WIDTH-1:0] C_ONE    = WIDTH'(1);

  if (INIT_A > MAX_VAL) begin : g_chk_init_a
    $error("INIT_A must not exceed MAX_VAL");
  end
  if (INIT_B > MAX_VAL) begin : g_chk_init_b
    $error("INIT_B must not exceed MAX_VAL");
  end
  if (MAX_VAL >= (1 << WIDTH)) begin : g_chk_width
    $error("MAX_VAL does not fit in WIDTH bits");
  end

  cnt_state_t       r_state;
  logic [WIDTH-1:0] r_cpt;
  logic             r_done;
  logic             w_run;

  assign w_run  = (r_state == CNT_RUN);
  assign busy_o = w_run;
  assign last_o = w_run && (r_cpt == C_MAX);
  assign data_o = r_cpt;
  assign done_o = r_done;

  // done is a pulse: cleared on every edge, even with en_i low, so it never stretches.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_state <= CNT_IDLE;
      r_cpt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (en_i) begin
        if (init_a_i) begin
          r_cpt   <= C_INIT_A;
          r_state <= CNT_RUN;
        end else if (init_b_i) begin
          r_cpt   <= C_INIT_B;
          r_state <= CNT_RUN;
        end else if (w_run) begin
          if (r_cpt == C_MAX) begin
            r_cpt   <= '0;
            r_state <= CNT_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_cpt <= r_cpt + C_ONE;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/compteur_rondes_param.md
Name: compteur_rondes_param

Overview:
Parametrised round counter with a run/idle state machine. It is the successor of the 2-bit init counter and sequences permutation rounds for the ASCON core. It loads one of two programmable start values: p12 starts at 0, p6 starts at 6. It then counts up to a programmable terminal value, flags the last round, and emits a one-cycle completion pulse to the control FSM.

Parameters:
WIDTH, 4, counter width in bits; must satisfy 2**WIDTH > MAX_VAL
MAX_VAL, 11, terminal round index (last value counted)
INIT_A, 0, start value loaded by init_a_i (p12)
INIT_B, 6, start value loaded by init_b_i (p6)

Ports:
clock_i  input  1  system clock, rising edge
resetb_i  input  1  reset, asynchronous, active-low
en_i  input  1  global enable; no load/count/state change when 0
init_a_i  input  1  load INIT_A and start a run (qualified by en_i)
init_b_i  input  1  load INIT_B and start a run (qualified by en_i)
data_o  output  WIDTH  current round index
busy_o  output  1  1 while in RUN
last_o  output  1  combinational: RUN and data_o == MAX_VAL
done_o  output  1  registered one-cycle pulse after the last round completes

Behaviour:
- Reset (resetb_i=0, async): cpt=0, state=IDLE, done_o=0. All outputs are 0 during reset. Reset mid-run aborts with no done_o.
- State IDLE:
  - en_i=1 & init_a_i=1: cpt<=INIT_A, go to RUN.
  - en_i=1 & init_a_i=0 & init_b_i=1: cpt<=INIT_B, go to RUN.
  - en_i=1 with no init: cpt holds, no counting in IDLE.
  - en_i=0: everything holds.
- State RUN, evaluated per rising edge with en_i=1:
  - init_a_i=1: restart, cpt<=INIT_A, stay in RUN, done_o stays 0. init_a_i has priority over init_b_i.
  - init_b_i=1 (init_a_i=0): restart, cpt<=INIT_B, stay in RUN.
  - No init and cpt<MAX_VAL: cpt<=cpt+1.
  - No init and cpt==MAX_VAL: cpt<=0, go to IDLE, done_o<=1 for exactly the next cycle.
- State RUN with en_i=0: cpt and state hold, last_o stays valid.
- done_o: registered, high for exactly one cycle after the terminal count, then cleared. It is never asserted on restart, reset or en_i=0.
- A run started at start value S spends MAX_VAL-S+1 enabled cycles in RUN. done_o rises on the edge ending the last of these.
- Boundary case INIT==MAX_VAL: one-round run. last_o=1 immediately after the load; the next enabled edge terminates the run.
- Init pulse on the same edge as the terminal count: init wins. The run restarts with no done_o.
- No wrap-around beyond MAX_VAL: cpt never exceeds MAX_VAL in RUN.
- Elaboration assertions: INIT_A<=MAX_VAL, INIT_B<=MAX_VAL, MAX_VAL<2**WIDTH.

Decomposition:
- ascon_pack carries:
  - typedef enum logic {CNT_IDLE, CNT_RUN} cnt_state_t;
  - constants ROUND_MAX=11, P12_START=0, P6_START=6 (used as defaults at instantiation).
- No sub-module. Single always_ff for cpt/state/done_o plus one assign for last_o/busy_o.

Test Plan:
- Reset then en_i=1, init_a_i pulse (one cycle):
  - data_o steps 0,1,...,11.
  - last_o=1 only while data_o=11.
  - done_o=1 exactly one cycle later; busy_o=0 and data_o=0 afterwards.
- init_b_i pulse: data_o runs 6..11, busy_o high for 6 cycles, single done_o pulse.
- Mid-run at data_o=3, deassert en_i for 4 cycles: data_o holds 3, last_o=0. The run then completes at 11 with one done_o.
- At data_o=11, assert init_b_i with en_i=1: data_o=6, still RUN, no done_o. Same-edge init_a_i+init_b_i gives data_o=0.
- Assert resetb_i=0 asynchronously at data_o=7 (between edges): data_o=0, busy_o=0, done_o=0 immediately, with no done_o afterwards.
- Parameter set WIDTH=3, MAX_VAL=5, INIT_B=5: the init_b run lasts one cycle with last_o=1, then done_o. IDLE with en_i=1 and no init keeps data_o at 0.
